// File: rtl/if_stage.sv
// Instruction fetch stage with a small in-order instruction queue.
//
// Fetches one word per cycle from a combinational instruction memory at
// fetch_pc, queues {pc, instr} pairs, and presents the oldest entry to decode
// with a valid/ready handshake. A redirect flushes the queue and restarts
// fetch at the (word-aligned) target.
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     queue depth, a power of two >= 2
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   start_i                   fetch enable
//   imem_addr_o/imem_instr_i  instruction memory address / returned word
//   redirect_i/redirect_pc_i  flush request and new fetch target
//   out_valid_o/out_ready_i   decode handshake
//   out_pc_o/out_instr_o      queue head payload
//   fetch_cnt_o/stall_cnt_o   performance counters, present only when the
//                             macro IF_STAGE_PERF_EN is defined
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_instr_o
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t             queue_q [DEPTH];

    logic [31:0]        fetch_pc_q;
    logic [31:0]        fetch_pc_d;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   head_d;
    logic [PTR_W-1:0]   tail_q;
    logic [PTR_W-1:0]   tail_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               valid_q;

    logic               pop_c;
    logic               push_c;

    // Target low bits are ignored; the target is always word aligned.
    logic [1:0]         unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    // Handshake: a push may reuse the slot freed by a same-cycle pop.
    always_comb begin
        pop_c  = valid_q & out_ready_i;
        push_c = start_i & ~redirect_i & ((count_q < CNT_W'(DEPTH)) | pop_c);
    end

    // Next-state for PC, pointers and occupancy; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push_c) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop_c) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; valid is kept as its own flop so it drops on reset at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
        end
    end

    // Queue storage, written at the tail; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            queue_q[tail_q] <= '{pc: fetch_pc_q, instr: imem_instr_i};
        end
    end

    assign imem_addr_o = fetch_pc_q;
    assign out_valid_o = valid_q;
    assign out_pc_o    = queue_q[head_q].pc;
    assign out_instr_o = queue_q[head_q].instr;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Push count and back-pressure cycle count, both free-running with wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push_c) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid_q && !out_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus a randomized run checked
// against a queue-based reference model. A second instance uses a RESET_PC
// near the top of the address space to exercise PC wrap-around.
module tb_if_stage;

    localparam int unsigned DEPTH   = 2;
    localparam logic [31:0] KEY     = 32'hDEAD_BEEF;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;

    logic [31:0] addr_a, instr_a, pc_a, oinstr_a;
    logic        valid_a;
    logic [31:0] addr_b, instr_b, pc_b, oinstr_b;
    logic        valid_b;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_cnt_a, stall_cnt_a, fetch_cnt_b, stall_cnt_b;
`endif

    int checks = 0;
    int passes = 0;

    // Reference model: queue of fetched PCs (instr is always pc ^ KEY).
    logic [31:0] m_q[$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    // Memory returns a scrambled copy of the address.
    assign instr_a = addr_a ^ KEY;
    assign instr_b = addr_b ^ KEY;

    if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .imem_addr_o(addr_a), .imem_instr_i(instr_a),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .out_valid_o(valid_a), .out_ready_i(ready),
        .out_pc_o(pc_a), .out_instr_o(oinstr_a)
`ifdef IF_STAGE_PERF_EN
        , .fetch_cnt_o(fetch_cnt_a), .stall_cnt_o(stall_cnt_a)
`endif
    );

    if_stage #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .imem_addr_o(addr_b), .imem_instr_i(instr_b),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .out_valid_o(valid_b), .out_ready_i(ready),
        .out_pc_o(pc_b), .out_instr_o(oinstr_b)
`ifdef IF_STAGE_PERF_EN
        , .fetch_cnt_o(fetch_cnt_b), .stall_cnt_o(stall_cnt_b)
`endif
    );

    // Drive one cycle from a negedge, advance the model at the posedge,
    // and return at the next negedge where outputs are sampled.
    task automatic drive_cycle(input logic s, input logic r, input logic rd,
                               input logic [31:0] rpc);
        bit do_pop, do_push;
        start = s; ready = r; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        if (rd) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            do_pop  = (m_q.size() != 0) && r;
            do_push = s && ((m_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Hold reset across one rising edge, release at a negedge.
    task automatic apply_reset(input logic s, input logic r);
        @(negedge clk);
        rst_n = 1'b0; start = s; ready = r; redirect = 1'b0; redirect_pc = '0;
        m_q.delete();
        m_pc = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        checks++; if (valid_a !== 1'b0) $display("FAIL reset valid_a: got %b want 0", valid_a); else passes++;
        checks++; if (addr_a !== 32'h0) $display("FAIL reset addr_a: got %h want 00000000", addr_a); else passes++;
        checks++; if (valid_b !== 1'b0) $display("FAIL reset valid_b: got %b want 0", valid_b); else passes++;
        checks++; if (addr_b !== WRAP_PC) $display("FAIL reset addr_b: got %h want %h", addr_b, WRAP_PC); else passes++;
        rst_n = 1'b1;
        m_q.delete();
        m_pc = 32'h0;
    endtask

    task automatic test_stream();
        apply_reset(1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            checks++; if (valid_a !== 1'b1) $display("FAIL stream valid k=%0d: got %b want 1", k, valid_a); else passes++;
            checks++; if (pc_a !== 32'(4 * k)) $display("FAIL stream pc k=%0d: got %h want %h", k, pc_a, 32'(4 * k)); else passes++;
            checks++; if (oinstr_a !== (32'(4 * k) ^ KEY)) $display("FAIL stream instr k=%0d: got %h want %h", k, oinstr_a, 32'(4 * k) ^ KEY); else passes++;
            checks++; if (addr_a !== 32'(4 * (k + 1))) $display("FAIL stream addr k=%0d: got %h want %h", k, addr_a, 32'(4 * (k + 1))); else passes++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b1, 1'b1);
        repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_a !== 32'h10) $display("FAIL bp start pc: got %h want 00000010", pc_a); else passes++;
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
            checks++; if (valid_a !== 1'b1 || pc_a !== 32'h10) $display("FAIL bp hold k=%0d: got v=%b pc=%h want v=1 pc=00000010", k, valid_a, pc_a); else passes++;
            checks++; if (oinstr_a !== (32'h10 ^ KEY)) $display("FAIL bp hold instr k=%0d: got %h want %h", k, oinstr_a, 32'h10 ^ KEY); else passes++;
        end
        checks++; if (addr_a !== 32'h18) $display("FAIL bp addr hold: got %h want 00000018", addr_a); else passes++;
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_a !== 32'h14) $display("FAIL bp order 2nd: got %h want 00000014", pc_a); else passes++;
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (pc_a !== 32'h18) $display("FAIL bp order 3rd: got %h want 00000018", pc_a); else passes++;
    endtask

    task automatic test_redirect();
        apply_reset(1'b1, 1'b0);
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (addr_a !== 32'h8 || pc_a !== 32'h0) $display("FAIL redir full: got addr=%h pc=%h want 00000008 00000000", addr_a, pc_a); else passes++;
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h103);
        checks++; if (valid_a !== 1'b0) $display("FAIL redir flush valid: got %b want 0", valid_a); else passes++;
        checks++; if (addr_a !== 32'h100) $display("FAIL redir addr: got %h want 00000100", addr_a); else passes++;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (valid_a !== 1'b1 || pc_a !== 32'h100) $display("FAIL redir first: got v=%b pc=%h want v=1 pc=00000100", valid_a, pc_a); else passes++;
        checks++; if (oinstr_a !== (32'h100 ^ KEY)) $display("FAIL redir instr: got %h want %h", oinstr_a, 32'h100 ^ KEY); else passes++;
        checks++; if (addr_a !== 32'h104) $display("FAIL redir next addr: got %h want 00000104", addr_a); else passes++;
    endtask

    task automatic test_start_low();
        apply_reset(1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (valid_a !== 1'b0 || addr_a !== 32'h0) $display("FAIL idle: got v=%b addr=%h want v=0 addr=00000000", valid_a, addr_a); else passes++;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (valid_a !== 1'b1 || pc_a !== 32'h0) $display("FAIL idle single: got v=%b pc=%h want v=1 pc=00000000", valid_a, pc_a); else passes++;
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (valid_a !== 1'b0 || addr_a !== 32'h4) $display("FAIL idle drain: got v=%b addr=%h want v=0 addr=00000004", valid_a, addr_a); else passes++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        apply_reset(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            checks++; if (valid_b !== 1'b1 || pc_b !== exp_pc[k]) $display("FAIL wrap k=%0d: got v=%b pc=%h want v=1 pc=%h", k, valid_b, pc_b, exp_pc[k]); else passes++;
            checks++; if (oinstr_b !== (exp_pc[k] ^ KEY)) $display("FAIL wrap instr k=%0d: got %h want %h", k, oinstr_b, exp_pc[k] ^ KEY); else passes++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1, 1'b1);
        repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (valid_a !== 1'b1) $display("FAIL async pre valid: got %b want 1", valid_a); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid_a !== 1'b0) $display("FAIL async valid drop: got %b want 0", valid_a); else passes++;
        checks++; if (addr_a !== 32'h0) $display("FAIL async addr: got %h want 00000000", addr_a); else passes++;
        m_q.delete();
        m_pc = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (valid_a !== 1'b1 || pc_a !== 32'h0) $display("FAIL async restart: got v=%b pc=%h want v=1 pc=00000000", valid_a, pc_a); else passes++;
    endtask

    task automatic test_random();
        logic s, r, rd;
        logic [31:0] rpc;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            checks++; if (addr_a !== m_pc) $display("FAIL rand addr i=%0d: got %h want %h", i, addr_a, m_pc); else passes++;
            checks++; if (valid_a !== (m_q.size() != 0)) $display("FAIL rand valid i=%0d: got %b want %b", i, valid_a, m_q.size() != 0); else passes++;
            if (m_q.size() != 0) begin
                checks++; if (pc_a !== m_q[0]) $display("FAIL rand pc i=%0d: got %h want %h", i, pc_a, m_q[0]); else passes++;
                checks++; if (oinstr_a !== (m_q[0] ^ KEY)) $display("FAIL rand instr i=%0d: got %h want %h", i, oinstr_a, m_q[0] ^ KEY); else passes++;
            end
            s   = ($urandom_range(3, 0) != 0);
            r   = ($urandom_range(1, 0) != 0);
            rd  = ($urandom_range(15, 0) == 0);
            rpc = $urandom();
            drive_cycle(s, r, rd, rpc);
        end
    endtask

`ifdef IF_STAGE_PERF_EN
    task automatic test_perf();
        apply_reset(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        start = 1'b0;
        checks++; if (fetch_cnt_a !== 32'd4) $display("FAIL perf fetch_cnt: got %0d want 4", fetch_cnt_a); else passes++;
        checks++; if (stall_cnt_a !== 32'd3) $display("FAIL perf stall_cnt: got %0d want 3", stall_cnt_a); else passes++;
    endtask
`endif

    // Time bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_pc = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_start_low();
        test_wrap();
        test_async_reset();
`ifdef IF_STAGE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
